// File: rtl/pipe_ir_chain_if.sv
// Pipeline IR chain bus.
// Carries the fetch input and the pipeline control inputs (flush, ext_stall)
// to the IR chain. Carries back the four pipeline IRs, the PC-advance enable,
// the load-use flag and the bubble counter.
//   master : drives fetch_ir/flush/ext_stall, observes IRs and status
//   slave  : the IR chain itself
interface pipe_ir_chain_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      fetch_ir;
  logic             flush;
  logic             ext_stall;
  logic [31:0]      FDIR;
  logic [31:0]      DXIR;
  logic [31:0]      XMIR;
  logic [31:0]      MWIR;
  logic             pc_advance;
  logic             load_use;
  logic [CNT_W-1:0] bubble_count;

  modport master (
    output fetch_ir, flush, ext_stall,
    input  FDIR, DXIR, XMIR, MWIR, pc_advance, load_use, bubble_count
  );

  modport slave (
    input  fetch_ir, flush, ext_stall,
    output FDIR, DXIR, XMIR, MWIR, pc_advance, load_use, bubble_count
  );
endinterface

// File: rtl/pipe_ir_chain.sv
// Instruction-register chain of the 5-stage pipeline.
// Holds the FD/DX/XM/MW IRs, detects load-use hazards, inserts bubbles,
// applies branch/jump flushes and multdiv stalls, and counts inserted bubbles
// in a saturating counter.
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset (all IRs = NOP, count = 0)
//   bus      pipe_ir_chain_if.slave: fetch_ir, flush, ext_stall in;
//            FDIR, DXIR, XMIR, MWIR, pc_advance, load_use, bubble_count out
module pipe_ir_chain #(
  parameter logic [31:0] NOP   = 32'h0000_0000,
  parameter int unsigned CNT_W = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  pipe_ir_chain_if.slave bus
);

  localparam logic [4:0] OP_ALU  = 5'd0;
  localparam logic [4:0] OP_BNE  = 5'd2;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_BLT  = 5'd6;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;

  typedef enum logic [1:0] {
    UPD_ADVANCE,
    UPD_BUBBLE,
    UPD_STALL,
    UPD_FLUSH
  } upd_e;

  logic [31:0]      fdIr, dxIr, xmIr, mwIr;
  logic [CNT_W-1:0] bubbleCount;
  logic [CNT_W-1:0] countNext;
  logic [CNT_W:0]   countSum;
  logic [1:0]       bubbleInc;
  upd_e             upd;

  logic [4:0] fdOp, fdRd, fdRs, fdRt, dxOp, dxRd;
  logic       readsRs, readsRt, readsRd;
  logic       loadUse;

  assign fdOp = fdIr[31:27];
  assign fdRd = fdIr[26:22];
  assign fdRs = fdIr[21:17];
  assign fdRt = fdIr[16:12];
  assign dxOp = dxIr[31:27];
  assign dxRd = dxIr[26:22];

  // Source-register usage of the instruction sitting in decode.
  always_comb begin
    readsRs = 1'b0;
    readsRt = 1'b0;
    readsRd = 1'b0;
    case (fdOp)
      OP_ALU:          begin readsRs = 1'b1; readsRt = 1'b1; end
      OP_ADDI, OP_LW:  readsRs = 1'b1;
      OP_SW:           begin readsRs = 1'b1; readsRd = 1'b1; end
      OP_BNE, OP_BLT:  begin readsRd = 1'b1; readsRs = 1'b1; end
      OP_JR:           readsRd = 1'b1;
      default:         ;
    endcase
  end

  // r0 is hard-wired zero, so a load into it never creates a dependency.
  assign loadUse = (dxOp == OP_LW) && (dxRd != 5'd0) &&
                   ((readsRs && (fdRs == dxRd)) ||
                    (readsRt && (fdRt == dxRd)) ||
                    (readsRd && (fdRd == dxRd)));

  // A resolved branch in X wins over any stall source.
  always_comb begin
    upd = UPD_ADVANCE;
    if (bus.flush)          upd = UPD_FLUSH;
    else if (bus.ext_stall) upd = UPD_STALL;
    else if (loadUse)       upd = UPD_BUBBLE;
  end

  // A flush only counts when it actually kills live instructions.
  always_comb begin
    bubbleInc = 2'd0;
    case (upd)
      UPD_FLUSH:   bubbleInc = ((fdIr == NOP) && (dxIr == NOP)) ? 2'd0 : 2'd2;
      UPD_STALL,
      UPD_BUBBLE:  bubbleInc = 2'd1;
      default:     bubbleInc = 2'd0;
    endcase
  end

  // Saturating add: carry out of the counter width pins the count at all-ones.
  assign countSum  = {1'b0, bubbleCount} + (CNT_W+1)'(bubbleInc);
  assign countNext = countSum[CNT_W] ? '1 : countSum[CNT_W-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fdIr        <= NOP;
      dxIr        <= NOP;
      xmIr        <= NOP;
      mwIr        <= NOP;
      bubbleCount <= '0;
    end else begin
      bubbleCount <= countNext;
      case (upd)
        UPD_FLUSH: begin
          fdIr <= NOP;
          dxIr <= NOP;
          xmIr <= dxIr;
          mwIr <= xmIr;
        end
        UPD_STALL: begin
          // Upstream stages freeze; MW gets a bubble so the instruction in
          // XM is not written back twice.
          mwIr <= NOP;
        end
        UPD_BUBBLE: begin
          dxIr <= NOP;
          xmIr <= dxIr;
          mwIr <= xmIr;
        end
        default: begin
          fdIr <= bus.fetch_ir;
          dxIr <= fdIr;
          xmIr <= dxIr;
          mwIr <= xmIr;
        end
      endcase
    end
  end

  assign bus.FDIR         = fdIr;
  assign bus.DXIR         = dxIr;
  assign bus.XMIR         = xmIr;
  assign bus.MWIR         = mwIr;
  assign bus.load_use     = loadUse;
  assign bus.pc_advance   = bus.flush | (~bus.ext_stall & ~loadUse);
  assign bus.bubble_count = bubbleCount;

endmodule

// File: tb/tb_pipe_ir_chain.sv
module tb_pipe_ir_chain;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  pipe_ir_chain_if #(.CNT_W(16)) bus16 ();
  pipe_ir_chain_if #(.CNT_W(2))  bus2 ();

  assign bus2.fetch_ir  = bus16.fetch_ir;
  assign bus2.flush     = bus16.flush;
  assign bus2.ext_stall = bus16.ext_stall;

  pipe_ir_chain #(.NOP(32'h0000_0000), .CNT_W(16)) dut16 (
    .clock(clock), .reset_n(reset_n), .bus(bus16.slave));
  pipe_ir_chain #(.NOP(32'h0000_0000), .CNT_W(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .bus(bus2.slave));

  int compared = 0;
  int failed   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit readsReg(input logic [31:0] ir, input logic [4:0] r);
    logic [4:0] rd, rs, rt;
    rd = ir[26:22]; rs = ir[21:17]; rt = ir[16:12];
    case (int'(ir[31:27]))
      0:    return (rs == r) || (rt == r);
      5, 8: return rs == r;
      7:    return (rs == r) || (rd == r);
      2, 6: return (rd == r) || (rs == r);
      4:    return rd == r;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit modelLoadUse(input logic [31:0] fd, input logic [31:0] dx);
    return (dx[31:27] == 5'd8) && (dx[26:22] != 5'd0) && readsReg(fd, dx[26:22]);
  endfunction

  logic [31:0] mFD, mDX, mXM, mMW;
  int          mCnt16, mCnt2;

  always @(posedge clock or negedge reset_n) begin : model
    int inc;
    if (!reset_n) begin
      mFD <= 0; mDX <= 0; mXM <= 0; mMW <= 0;
      mCnt16 <= 0; mCnt2 <= 0;
    end else begin
      if (bus16.flush) begin
        inc = (mFD == 0 && mDX == 0) ? 0 : 2;
        mFD <= 0; mDX <= 0; mXM <= mDX; mMW <= mXM;
      end else if (bus16.ext_stall) begin
        inc = 1;
        mMW <= 0;
      end else if (modelLoadUse(mFD, mDX)) begin
        inc = 1;
        mDX <= 0; mXM <= mDX; mMW <= mXM;
      end else begin
        inc = 0;
        mFD <= bus16.fetch_ir; mDX <= mFD; mXM <= mDX; mMW <= mXM;
      end
      mCnt16 <= (mCnt16 + inc > 65535) ? 65535 : mCnt16 + inc;
      mCnt2  <= (mCnt2 + inc > 3) ? 3 : mCnt2 + inc;
    end
  end

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clock) begin
    bit lu;
    lu = modelLoadUse(mFD, mDX);
    check("FDIR", bus16.FDIR, mFD);
    check("DXIR", bus16.DXIR, mDX);
    check("XMIR", bus16.XMIR, mXM);
    check("MWIR", bus16.MWIR, mMW);
    check("load_use", {31'd0, bus16.load_use}, {31'd0, lu});
    check("pc_advance", {31'd0, bus16.pc_advance},
          {31'd0, bus16.flush | (!bus16.ext_stall && !lu)});
    check("bubble_count", {16'd0, bus16.bubble_count}, mCnt16);
    check("sat_FDIR", bus2.FDIR, mFD);
    check("sat_bubble_count", {30'd0, bus2.bubble_count}, mCnt2);
  end

  // ---------------- directed stimulus ----------------
  task automatic setIn(input logic [31:0] f, input logic fl, input logic st);
    bus16.fetch_ir  = f;
    bus16.flush     = fl;
    bus16.ext_stall = st;
    #1;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  localparam logic [31:0] LW_R3  = 32'h40C0_0000;
  localparam logic [31:0] ADD_U3 = 32'h0106_5000;
  localparam logic [31:0] LW_R0  = 32'h4000_0000;
  localparam logic [31:0] ADD_U0 = 32'h0100_5000;
  localparam logic [31:0] I1     = 32'h2882_0001;
  localparam logic [31:0] I2     = 32'h0800_0000;
  localparam logic [31:0] I3     = 32'h38C4_0000;

  logic [31:0] hazTab [6] = '{32'h41C0_0000, 32'h39C0_0000, 32'h41C0_0000,
                              32'h100E_0000, 32'h2000_0000, 32'h01C0_0000};

  initial begin
    reset_n = 1'b0;
    setIn(32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    check("rst_FDIR", bus16.FDIR, 32'h0);
    check("rst_MWIR", bus16.MWIR, 32'h0);
    check("rst_count", {16'd0, bus16.bubble_count}, 32'd0);
    check("rst_load_use", {31'd0, bus16.load_use}, 32'd0);
    check("rst_pc_advance", {31'd0, bus16.pc_advance}, 32'd1);

    // load-use: lw r3 followed by add r4,r3,r5
    setIn(LW_R3, 1'b0, 1'b0); tick;
    setIn(ADD_U3, 1'b0, 1'b0); tick;
    setIn(32'h2000_0000, 1'b0, 1'b0);
    check("lu_load_use", {31'd0, bus16.load_use}, 32'd1);
    check("lu_pc_advance", {31'd0, bus16.pc_advance}, 32'd0);
    tick;
    check("lu_FDIR_hold", bus16.FDIR, ADD_U3);
    check("lu_DXIR_nop", bus16.DXIR, 32'h0);
    check("lu_XMIR", bus16.XMIR, LW_R3);
    check("lu_count", {16'd0, bus16.bubble_count}, 32'd1);
    check("lu_cleared", {31'd0, bus16.load_use}, 32'd0);

    // r0 exclusion
    setIn(LW_R0, 1'b0, 1'b0); tick;
    setIn(ADD_U0, 1'b0, 1'b0); tick;
    check("r0_load_use", {31'd0, bus16.load_use}, 32'd0);
    check("r0_pc_advance", {31'd0, bus16.pc_advance}, 32'd1);
    setIn(32'h2000_0000, 1'b0, 1'b0); tick;
    check("r0_FDIR", bus16.FDIR, 32'h2000_0000);
    check("r0_DXIR", bus16.DXIR, ADD_U0);
    check("r0_count", {16'd0, bus16.bubble_count}, 32'd1);

    // flush with live FD/DX, then flush with both already NOP
    setIn(32'h2800_0000, 1'b1, 1'b0);
    check("fl_pc_advance", {31'd0, bus16.pc_advance}, 32'd1);
    tick;
    check("fl_FDIR", bus16.FDIR, 32'h0);
    check("fl_DXIR", bus16.DXIR, 32'h0);
    check("fl_XMIR", bus16.XMIR, ADD_U0);
    check("fl_count", {16'd0, bus16.bubble_count}, 32'd3);
    tick;
    check("fl_nop_count", {16'd0, bus16.bubble_count}, 32'd3);
    check("sat_reached", {30'd0, bus2.bubble_count}, 32'd3);

    // ext_stall for 3 cycles
    setIn(I1, 1'b0, 1'b0); tick;
    setIn(I2, 1'b0, 1'b0); tick;
    setIn(I3, 1'b0, 1'b0); tick;
    setIn(32'hDEAD_BEEF, 1'b0, 1'b1);
    check("st_pc_advance", {31'd0, bus16.pc_advance}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("st_FDIR", bus16.FDIR, I3);
      check("st_DXIR", bus16.DXIR, I2);
      check("st_XMIR", bus16.XMIR, I1);
      check("st_MWIR", bus16.MWIR, 32'h0);
    end
    check("st_count", {16'd0, bus16.bubble_count}, 32'd6);

    // simultaneous flush + ext_stall
    setIn(32'hDEAD_BEEF, 1'b1, 1'b1);
    check("fs_pc_advance", {31'd0, bus16.pc_advance}, 32'd1);
    tick;
    check("fs_FDIR", bus16.FDIR, 32'h0);
    check("fs_XMIR", bus16.XMIR, I2);
    check("fs_count", {16'd0, bus16.bubble_count}, 32'd8);
    check("sat_hold", {30'd0, bus2.bubble_count}, 32'd3);

    // reset asserted mid-stall
    setIn(I1, 1'b0, 1'b0); tick;
    setIn(I2, 1'b0, 1'b1); tick;
    reset_n = 1'b0;
    #1;
    check("mr_FDIR", bus16.FDIR, 32'h0);
    check("mr_XMIR", bus16.XMIR, 32'h0);
    check("mr_count", {16'd0, bus16.bubble_count}, 32'd0);
    check("mr_sat_count", {30'd0, bus2.bubble_count}, 32'd0);
    setIn(32'h1234_5678, 1'b0, 1'b0); tick;
    reset_n = 1'b1;
    tick;
    check("mr_first_adv", bus16.FDIR, 32'h1234_5678);
    check("mr_first_count", {16'd0, bus16.bubble_count}, 32'd0);

    // hazard mix checked by the model
    for (int i = 0; i < 6; i++) begin
      setIn(hazTab[i], 1'b0, 1'b0);
      tick;
    end
    repeat (6) begin
      setIn(32'h0, 1'b0, 1'b0);
      tick;
    end

    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
